// File: rtl/vga_text_fetch_pkg.sv
// Shared definitions for the VGA text-mode read sequencer: geometry defaults,
// FSM encoding and the layout of a character/attribute cell word.
package vga_text_fetch_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned ROWS_DEF   = 30;
  localparam int unsigned CHAR_H_DEF = 16;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned COL_W    = 7;
  localparam int unsigned CHAR_LSB = 0;
  localparam int unsigned ATTR_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // One queued cell: raw RAM word plus its column tag and end-of-line flag.
  typedef struct packed {
    logic [15:0]      word;
    logic [COL_W-1:0] col;
    logic             last;
  } cell_t;

endpackage

// File: rtl/vga_text_fetch_if.sv
// Bundle of timing pulses, RAM port B and the cell handshake around the fetcher.
// master = the fetcher itself, slave = the surrounding timing/RAM/pixel logic.
interface vga_text_fetch_if;
  import vga_text_fetch_pkg::*;

  logic              frame_start_i;
  logic              line_start_i;
  logic [ADDR_W-1:0] scroll_i;
  logic              ram_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [15:0]       ram_data_i;
  logic              cell_valid_o;
  logic              cell_ready_i;
  logic [7:0]        cell_char_o;
  logic [7:0]        cell_attr_o;
  logic [COL_W-1:0]  cell_col_o;
  logic              cell_last_o;
  logic [11:0]       font_addr_o;
  logic              overrun_o;

  modport master (
    input  frame_start_i, line_start_i, scroll_i, ram_data_i, cell_ready_i,
    output ram_en_o, ram_addr_o, cell_valid_o, cell_char_o, cell_attr_o,
           cell_col_o, cell_last_o, font_addr_o, overrun_o
  );

  modport slave (
    output frame_start_i, line_start_i, scroll_i, ram_data_i, cell_ready_i,
    input  ram_en_o, ram_addr_o, cell_valid_o, cell_char_o, cell_attr_o,
           cell_col_o, cell_last_o, font_addr_o, overrun_o
  );
endinterface

// File: rtl/vga_fetch_fifo2.sv
// Two-entry first-word-fall-through FIFO holding fetched cells; flush empties it
// in one cycle and wins over a simultaneous push.
module vga_fetch_fifo2
  import vga_text_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  cell_t      push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output cell_t      head_o,
  output logic [1:0] count_o
);

  cell_t      mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; only the occupancy count decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vga_text_fetch.sv
// Per-scanline reader of the character/attribute RAM: issues port-B reads,
// absorbs the 1-cycle read latency and hands cells downstream via valid/ready.
module vga_text_fetch
  import vga_text_fetch_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned CHAR_H = CHAR_H_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vga_text_fetch_if.master  bus
);

  fetch_state_e      state_q, state_d;
  logic [COL_W-1:0]  col_issue_q, col_issue_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        scan_q, scan_d;
  logic [6:0]        row_q, row_d;
  logic              overrun_q, overrun_d;
  logic              infl_q, infl_d;
  logic [COL_W-1:0]  infl_col_q;
  logic              infl_last_q;

  cell_t      head;
  logic       fifo_valid;
  logic [1:0] fifo_count;
  logic       ram_en, issue_last, pop, last_accept;
  logic [2:0] fill_after;

  vga_fetch_fifo2 u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.frame_start_i),
    .push_i      (infl_q),
    .push_data_i ('{word: bus.ram_data_i, col: infl_col_q, last: infl_last_q}),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      col_issue_q <= '0;
      base_q      <= '0;
      scan_q      <= '0;
      row_q       <= '0;
      overrun_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_col_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_issue_q <= col_issue_d;
      base_q      <= base_d;
      scan_q      <= scan_d;
      row_q       <= row_d;
      overrun_q   <= overrun_d;
      infl_q      <= infl_d;
      infl_col_q  <= col_issue_q;
      infl_last_q <= issue_last;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    col_issue_d = col_issue_q;
    base_d      = base_q;
    scan_d      = scan_q;
    row_d       = row_q;
    overrun_d   = overrun_q;
    infl_d      = ram_en;
    if (bus.frame_start_i) begin
      state_d     = ST_IDLE;
      col_issue_d = '0;
      base_d      = bus.scroll_i;
      scan_d      = '0;
      row_d       = '0;
      overrun_d   = 1'b0;
      infl_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.line_start_i) begin
            state_d     = ST_FETCH;
            col_issue_d = '0;
          end
        end
        ST_FETCH: begin
          if (bus.line_start_i) overrun_d = 1'b1;
          if (ram_en) begin
            col_issue_d = col_issue_q + COL_W'(1);
            if (issue_last) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.line_start_i) overrun_d = 1'b1;
          if (last_accept) begin
            state_d = ST_IDLE;
            if (scan_q == 4'(CHAR_H - 1)) begin
              scan_d = '0;
              row_d  = row_q + 7'd1;
              base_d = base_q + ADDR_W'(COLS);
              if (row_q == 7'(ROWS - 1)) state_d = ST_DONE;
            end else begin
              scan_d = scan_q + 4'd1;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop         = fifo_valid && bus.cell_ready_i;
    // A cell leaving this cycle frees its slot, so back-to-back issue is possible.
    fill_after  = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, pop};
    ram_en      = (state_q == ST_FETCH) && (fill_after < 3'd2);
    issue_last  = (col_issue_q == COL_W'(COLS - 1));
    last_accept = (state_q == ST_DRAIN) && pop && head.last;

    bus.ram_en_o     = ram_en;
    bus.ram_addr_o   = base_q + ADDR_W'(col_issue_q);
    bus.cell_valid_o = fifo_valid;
    bus.cell_char_o  = fifo_valid ? head.word[CHAR_LSB +: 8] : 8'h00;
    bus.cell_attr_o  = fifo_valid ? head.word[ATTR_LSB +: 8] : 8'h00;
    bus.cell_col_o   = fifo_valid ? head.col : '0;
    bus.cell_last_o  = fifo_valid && head.last;
    bus.font_addr_o  = {bus.cell_char_o, scan_q};
    bus.overrun_o    = overrun_q;
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch: a behavioural 1-cycle-latency RAM feeds the
// fetcher and each scenario task checks the address and cell streams it sees.
module tb_vga_text_fetch;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_H = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] ram_mem [2048];
  logic [15:0] ram_q;

  vga_text_fetch_if bus ();

  vga_text_fetch #(.COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.ram_en_o) ram_q <= ram_mem[bus.ram_addr_o];
  assign bus.ram_data_i = ram_q;

  task automatic pulse_frame(input logic [10:0] scroll);
    @(negedge clk);
    bus.frame_start_i = 1'b1;
    bus.scroll_i      = scroll;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
  endtask

  // One scanline: line_start at cycle 0, then observe every cycle until all cells accepted.
  task automatic run_line(input logic [10:0] base, input logic [3:0] scan, input bit stall,
                          input bit mid_ls, output logic [7:0] c5_char,
                          output logic [7:0] c5_attr, output logic [11:0] c5_font);
    int          n_iss, n_acc, first_k, last_k;
    bit          prev_stall, pop;
    logic [23:0] prev_pl, cur_pl;
    logic [15:0] w;
    logic [10:0] a;
    n_iss = 0; n_acc = 0; first_k = -1; last_k = -1;
    prev_stall = 1'b0; prev_pl = '0;
    c5_char = '0; c5_attr = '0; c5_font = '0;
    @(negedge clk);
    bus.line_start_i = 1'b1;
    bus.cell_ready_i = !stall;
    for (int k = 1; k <= 400 && n_acc < COLS; k++) begin
      @(negedge clk);
      bus.line_start_i = mid_ls && (k == 10);
      bus.cell_ready_i = stall ? (k % 3 == 0) : 1'b1;
      #1;
      pop    = bus.cell_valid_o && bus.cell_ready_i;
      cur_pl = {bus.cell_char_o, bus.cell_attr_o, bus.cell_col_o, bus.cell_last_o};
      if (bus.cell_valid_o && first_k < 0) first_k = k;
      if (prev_stall) begin
        checks++;
        if (!bus.cell_valid_o || cur_pl !== prev_pl) begin
          errors++;
          $display("FAIL stall_hold k=%0d got valid=%b payload=%h expected valid=1 payload=%h",
                   k, bus.cell_valid_o, cur_pl, prev_pl);
        end
      end
      if (!stall) begin
        checks++;
        if (bus.ram_en_o !== (k <= COLS)) begin
          errors++;
          $display("FAIL ram_en_schedule k=%0d got %b expected %b", k, bus.ram_en_o, (k <= COLS));
        end
      end
      if (bus.ram_en_o) begin
        checks++;
        if (n_iss >= COLS || (n_iss - n_acc - int'(pop)) >= 2) begin
          errors++;
          $display("FAIL issue_room k=%0d got issued=%0d accepted=%0d pop=%b expected room for issue",
                   k, n_iss, n_acc, pop);
        end
        a = base + 11'(n_iss);
        checks++;
        if (bus.ram_addr_o !== a) begin
          errors++;
          $display("FAIL ram_addr issue=%0d got %0d expected %0d", n_iss, bus.ram_addr_o, a);
        end
        n_iss++;
      end
      if (pop) begin
        a = base + 11'(n_acc);
        w = ram_mem[a];
        checks++;
        if (bus.cell_col_o !== 7'(n_acc) || bus.cell_char_o !== w[7:0] ||
            bus.cell_attr_o !== w[15:8] || bus.cell_last_o !== (n_acc == COLS - 1) ||
            bus.font_addr_o !== {w[7:0], scan}) begin
          errors++;
          $display("FAIL cell[%0d] got col=%0d char=%h attr=%h last=%b font=%h expected col=%0d char=%h attr=%h last=%b font=%h",
                   n_acc, bus.cell_col_o, bus.cell_char_o, bus.cell_attr_o, bus.cell_last_o,
                   bus.font_addr_o, n_acc, w[7:0], w[15:8], (n_acc == COLS - 1), {w[7:0], scan});
        end
        if (n_acc == 5) begin
          c5_char = bus.cell_char_o;
          c5_attr = bus.cell_attr_o;
          c5_font = bus.font_addr_o;
        end
        if (n_acc == COLS - 1) last_k = k;
        n_acc++;
      end
      prev_stall = bus.cell_valid_o && !bus.cell_ready_i;
      prev_pl    = cur_pl;
    end
    bus.line_start_i = 1'b0;
    checks++;
    if (n_acc != COLS || n_iss != COLS) begin
      errors++;
      $display("FAIL line_count base=%0d scan=%0d got issued=%0d accepted=%0d expected %0d each",
               base, scan, n_iss, n_acc, COLS);
    end
    if (!stall) begin
      checks++;
      if (first_k != 3 || last_k != COLS + 2) begin
        errors++;
        $display("FAIL latency got first=%0d last=%0d expected first=3 last=%0d",
                 first_k, last_k, COLS + 2);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== 11'd0 || bus.cell_valid_o !== 1'b0 ||
        bus.overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got en=%b addr=%0d valid=%b overrun=%b expected all 0",
               bus.ram_en_o, bus.ram_addr_o, bus.cell_valid_o, bus.overrun_o);
    end
    checks++;
    if (bus.cell_char_o !== 8'h00 || bus.cell_attr_o !== 8'h00 || bus.cell_col_o !== 7'd0 ||
        bus.cell_last_o !== 1'b0 || bus.font_addr_o !== 12'h000) begin
      errors++;
      $display("FAIL reset_cell got char=%h attr=%h col=%0d last=%b font=%h expected all 0",
               bus.cell_char_o, bus.cell_attr_o, bus.cell_col_o, bus.cell_last_o, bus.font_addr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_line();
    logic [7:0] c, a; logic [11:0] f;
    pulse_frame(11'd0);
    run_line(11'd0, 4'd0, 1'b0, 1'b0, c, a, f);
  endtask

  task automatic test_stall();
    logic [7:0] c, a; logic [11:0] f;
    run_line(11'd0, 4'd1, 1'b1, 1'b0, c, a, f);
  endtask

  task automatic test_font();
    logic [7:0] c, a; logic [11:0] f;
    run_line(11'd0, 4'd2, 1'b0, 1'b0, c, a, f);
    run_line(11'd0, 4'd3, 1'b0, 1'b0, c, a, f);
    checks++;
    if (c !== 8'h41 || a !== 8'h1E || f !== 12'h413) begin
      errors++;
      $display("FAIL font_cell5 got char=%h attr=%h font=%h expected char=41 attr=1e font=413", c, a, f);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] c, a; logic [11:0] f;
    pulse_frame(11'd2000);
    for (int s = 0; s < CHAR_H; s++) run_line(11'd2000, 4'(s), 1'b0, 1'b0, c, a, f);
    run_line(11'd32, 4'd0, 1'b0, 1'b0, c, a, f);
  endtask

  task automatic test_overrun();
    logic [7:0] c, a; logic [11:0] f;
    run_line(11'd32, 4'd1, 1'b0, 1'b1, c, a, f);
    checks++;
    if (bus.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b expected 1", bus.overrun_o);
    end
  endtask

  task automatic test_frame_abort();
    logic [7:0] c, a; logic [11:0] f;
    @(negedge clk);
    bus.line_start_i = 1'b1;
    bus.cell_ready_i = 1'b0;
    @(negedge clk);
    bus.line_start_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus.cell_valid_o !== 1'b1 || bus.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got valid=%b overrun=%b expected valid=1 overrun=1",
               bus.cell_valid_o, bus.overrun_o);
    end
    pulse_frame(11'd100);
    #1;
    checks++;
    if (bus.cell_valid_o !== 1'b0 || bus.overrun_o !== 1'b0 || bus.ram_en_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush got valid=%b overrun=%b en=%b expected all 0",
               bus.cell_valid_o, bus.overrun_o, bus.ram_en_o);
    end
    run_line(11'd100, 4'd0, 1'b0, 1'b0, c, a, f);
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    bus.line_start_i = 1'b1;
    bus.cell_ready_i = 1'b0;
    @(negedge clk);
    bus.line_start_i = 1'b0;
    @(negedge clk);
    bus.line_start_i = 1'b1;
    @(negedge clk);
    bus.line_start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cell_valid_o !== 1'b0 || bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== 11'd0 ||
        bus.overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b en=%b addr=%0d overrun=%b expected all 0",
               bus.cell_valid_o, bus.ram_en_o, bus.ram_addr_o, bus.overrun_o);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.cell_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got valid=%b expected 0", bus.cell_valid_o);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] c, a; logic [11:0] f;
    bit seen_en, seen_valid;
    pulse_frame(11'd300);
    for (int i = 0; i < ROWS * CHAR_H; i++)
      run_line(11'((300 + (i / CHAR_H) * COLS) % 2048), 4'(i % CHAR_H), 1'b0, 1'b0, c, a, f);
    seen_en = 1'b0; seen_valid = 1'b0;
    @(negedge clk);
    bus.line_start_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.line_start_i = 1'b0;
      #1;
      if (bus.ram_en_o) seen_en = 1'b1;
      if (bus.cell_valid_o) seen_valid = 1'b1;
    end
    checks++;
    if (seen_en || seen_valid || bus.overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore got en=%b valid=%b overrun=%b expected all 0",
               seen_en, seen_valid, bus.overrun_o);
    end
    pulse_frame(11'd7);
    run_line(11'd7, 4'd0, 1'b0, 1'b0, c, a, f);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ram_q  = 16'h0000;
    for (int i = 0; i < 2048; i++) ram_mem[i] = 16'((i * 29) ^ 16'hA5C3);
    ram_mem[5] = 16'h1E41;
    bus.frame_start_i = 1'b0;
    bus.line_start_i  = 1'b0;
    bus.scroll_i      = 11'd0;
    bus.cell_ready_i  = 1'b1;
    rst = 1'b1;

    test_reset();
    test_first_line();
    test_stall();
    test_font();
    test_wrap();
    test_overrun();
    test_frame_abort();
    test_reset_mid_fetch();
    test_full_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
